// File: rtl/mac_requant_pkg.sv
// rtl/mac_requant_pkg.sv - shared sizing, saturation and rounding helpers for the MAC/requant path
package mac_requant_pkg;

  localparam int DEF_DECIMAL_POINT = 4;

  function automatic int acc_width(input int width, input int vec_len);
    return 2 * width + $clog2(vec_len) + 1;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  function automatic int round_const(input int dp);
    return 1 << (dp - 1);
  endfunction

  localparam int ROUND_CONST = round_const(DEF_DECIMAL_POINT);

endpackage

// File: rtl/sat_round_sign.sv
// rtl/sat_round_sign.sv - combinational round-half-up and saturate from accumulator to WIDTH bits
module sat_round_sign
  import mac_requant_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DECIMAL_POINT = 4,
  parameter int ACC_WIDTH     = acc_width(8, 16)
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [WIDTH-1:0]     result_o,
  output logic                        sat_o
);

  localparam longint MAX_L = sat_max(WIDTH);
  localparam longint MIN_L = sat_min(WIDTH);
  localparam logic signed [ACC_WIDTH:0] MAX_W = MAX_L[ACC_WIDTH:0];
  localparam logic signed [ACC_WIDTH:0] MIN_W = MIN_L[ACC_WIDTH:0];
  localparam logic signed [ACC_WIDTH:0] RND_W = (ACC_WIDTH + 1)'(round_const(DECIMAL_POINT));

  // One guard bit so adding the rounding constant can never wrap.
  logic signed [ACC_WIDTH:0] sum_w;
  logic signed [ACC_WIDTH:0] r_w;

  assign sum_w = {acc_i[ACC_WIDTH-1], acc_i} + RND_W;
  assign r_w   = sum_w >>> DECIMAL_POINT;

  always_comb begin
    sat_o    = 1'b0;
    result_o = r_w[WIDTH-1:0];
    if (r_w > MAX_W) begin
      result_o = MAX_W[WIDTH-1:0];
      sat_o    = 1'b1;
    end else if (r_w < MIN_W) begin
      result_o = MIN_W[WIDTH-1:0];
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/mac_requant_sign.sv
// rtl/mac_requant_sign.sv - streamed signed dot product plus bias, requantized with rdy pulse
module mac_requant_sign
  import mac_requant_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DECIMAL_POINT = 4,
  parameter int VEC_LEN       = 16,
  parameter int ACC_WIDTH     = acc_width(WIDTH, VEC_LEN)
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] data,
  input  logic signed [WIDTH-1:0] weight,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] dataOut,
  output logic                    rdy,
  output logic                    sat
);

  localparam int CW = $clog2(VEC_LEN);
  localparam int PW = 2 * WIDTH;

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          first_w, last_w;
  logic                          valid1_q, first1_q, last1_q;
  logic signed [PW-1:0]          prod1_q, prod_d;
  logic signed [WIDTH-1:0]       bias1_q;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          done2_q;
  logic signed [WIDTH-1:0]       dout_q, res_w;
  logic                          rdy_q, sat_q, sat_w;

  assign first_w = (cnt_q == '0);
  assign last_w  = (cnt_q == CW'(VEC_LEN - 1));
  assign prod_d  = PW'(data) * PW'(weight);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = last_w ? '0 : cnt_q + CW'(1);
    end
  end

  // First element re-seeds from bias so back-to-back vectors never mix.
  always_comb begin
    acc_d = acc_q;
    if (valid1_q) begin
      acc_d = (first1_q ? (ACC_WIDTH'(bias1_q) <<< DECIMAL_POINT) : acc_q) + ACC_WIDTH'(prod1_q);
    end
  end

  sat_round_sign #(
    .WIDTH        (WIDTH),
    .DECIMAL_POINT(DECIMAL_POINT),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_sat_round (
    .acc_i   (acc_q),
    .result_o(res_w),
    .sat_o   (sat_w)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q    <= '0;
      valid1_q <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      prod1_q  <= '0;
      bias1_q  <= '0;
      acc_q    <= '0;
      done2_q  <= 1'b0;
      dout_q   <= '0;
      rdy_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      valid1_q <= enable;
      if (enable) begin
        prod1_q  <= prod_d;
        bias1_q  <= bias;
        first1_q <= first_w;
        last1_q  <= last_w;
      end
      acc_q   <= acc_d;
      done2_q <= valid1_q && last1_q;
      rdy_q   <= done2_q;
      if (done2_q) begin
        dout_q <= res_w;
        sat_q  <= sat_w;
      end
    end
  end

  assign dataOut = dout_q;
  assign rdy     = rdy_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_mac_requant_sign.sv
// tb/tb_mac_requant_sign.sv - scoreboard bench for mac_requant_sign with VEC_LEN=4
module tb_mac_requant_sign;

  typedef int vec_t[4];
  typedef struct {
    int cyc;
    int val;
    bit sat;
  } res_t;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic enable = 1'b0;
  logic signed [7:0] data = '0;
  logic signed [7:0] weight = '0;
  logic signed [7:0] bias = '0;
  logic signed [7:0] dataOut;
  logic rdy;
  logic sat;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  mac_requant_sign #(
    .WIDTH(8), .DECIMAL_POINT(4), .VEC_LEN(4)
  ) dut (
    .iClk(iClk), .iRst(iRst), .enable(enable), .data(data), .weight(weight),
    .bias(bias), .dataOut(dataOut), .rdy(rdy), .sat(sat)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    res_t o;
    #1;
    cyc++;
    if (rdy) begin
      o.cyc = cyc;
      o.val = int'(dataOut);
      o.sat = sat;
      obs_q.push_back(o);
    end
  end

  task automatic drive(input int d, input int w, input int b, input bit en);
    data   = 8'(d);
    weight = 8'(w);
    bias   = 8'(b);
    enable = en;
    @(posedge iClk);
    #2;
  endtask

  task automatic run_vec(input int b, input vec_t d, input vec_t w, input int ev, input bit es,
                         input int bub_at, input int bub_n);
    res_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == bub_at) begin
        for (int k = 0; k < bub_n; k++) drive(0, 0, 0, 1'b0);
      end
      drive(d[i], w[i], (i == 0) ? b : 8'h55, 1'b1);
    end
    enable = 1'b0;
    e.cyc = cyc + 2;
    e.val = ev;
    e.sat = es;
    exp_q.push_back(e);
  endtask

  function automatic int model(input int b, input vec_t d, input vec_t w, output bit s);
    int acc, r;
    acc = b * 16;
    for (int i = 0; i < 4; i++) acc += d[i] * w[i];
    r = (acc + 8) >>> 4;
    s = 1'b0;
    if (r > 127) begin r = 127; s = 1'b1; end
    if (r < -128) begin r = -128; s = 1'b1; end
    return r;
  endfunction

  task automatic check_out(input string name, output int got_cyc);
    res_t o, e;
    int n = 0;
    got_cyc = -1;
    while (obs_q.size() == 0 && n < 20) begin
      @(posedge iClk);
      #2;
      n++;
    end
    if (exp_q.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    compared++;
    if (obs_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: timeout, no rdy seen, required value %0d", name, e.val);
      return;
    end
    o = obs_q.pop_front();
    got_cyc = o.cyc;
    if (o.val !== e.val) begin
      mismatched++;
      $display("FAIL %s dataOut: got %0d required %0d", name, o.val, e.val);
    end
    compared++;
    if (o.sat !== e.sat) begin
      mismatched++;
      $display("FAIL %s sat: got %0b required %0b", name, o.sat, e.sat);
    end
    compared++;
    if (o.cyc !== e.cyc) begin
      mismatched++;
      $display("FAIL %s rdy cycle: got %0d required %0d", name, o.cyc, e.cyc);
    end
  endtask

  task automatic check_idle(input string name, input int hold_val);
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 1'b0);
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s extra rdy: got %0d pulses required 0", name, obs_q.size());
      obs_q.delete();
    end
    compared++;
    if (int'(dataOut) !== hold_val) begin
      mismatched++;
      $display("FAIL %s dataOut hold: got %0d required %0d", name, int'(dataOut), hold_val);
    end
  endtask

  task automatic test_reset();
    compared++;
    if (dataOut !== 8'sd0) begin mismatched++; $display("FAIL reset dataOut: got %0d required 0", dataOut); end
    compared++;
    if (rdy !== 1'b0) begin mismatched++; $display("FAIL reset rdy: got %0b required 0", rdy); end
    compared++;
    if (sat !== 1'b0) begin mismatched++; $display("FAIL reset sat: got %0b required 0", sat); end
    iRst = 1'b0;
  endtask

  task automatic test_basic();
    int c;
    run_vec(0, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 64, 1'b0, -1, 0);
    check_out("basic", c);
    check_idle("basic", 64);
  endtask

  task automatic test_saturation();
    int c;
    run_vec(0, '{127, 127, 127, 127}, '{127, 127, 127, 127}, 127, 1'b1, -1, 0);
    check_out("sat_pos", c);
    run_vec(0, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, -128, 1'b1, -1, 0);
    check_out("sat_neg", c);
  endtask

  task automatic test_rounding();
    int c;
    run_vec(0, '{1, 0, 0, 0}, '{8, 0, 0, 0}, 1, 1'b0, -1, 0);
    check_out("round_half", c);
    run_vec(0, '{1, 0, 0, 0}, '{7, 0, 0, 0}, 0, 1'b0, -1, 0);
    check_out("round_below", c);
    run_vec(0, '{-1, 0, 0, 0}, '{8, 0, 0, 0}, 0, 1'b0, -1, 0);
    check_out("round_neg_half", c);
    run_vec(0, '{-1, 0, 0, 0}, '{9, 0, 0, 0}, -1, 1'b0, -1, 0);
    check_out("round_neg_below", c);
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    run_vec(-32, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 32, 1'b0, -1, 0);
    run_vec(16, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 16, 1'b0, -1, 0);
    check_out("bias_neg", c1);
    check_out("bias_b2b", c2);
    compared++;
    if (c2 - c1 !== 4) begin
      mismatched++;
      $display("FAIL b2b spacing: got %0d required 4", c2 - c1);
    end
    check_idle("b2b", 16);
  endtask

  task automatic test_bubbles();
    int c;
    run_vec(0, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 64, 1'b0, 2, 3);
    check_out("bubbles", c);
    check_idle("bubbles", 64);
  endtask

  task automatic test_reset_mid();
    int c;
    drive(0, 0, 0, 1'b0);
    drive(0, 127, 127, 1'b1);
    drive(127, 127, 0, 1'b1);
    iRst = 1'b1;
    drive(127, 127, 0, 1'b1);
    iRst = 1'b0;
    enable = 1'b0;
    compared++;
    if (dataOut !== 8'sd0) begin mismatched++; $display("FAIL rst_mid dataOut: got %0d required 0", dataOut); end
    compared++;
    if (rdy !== 1'b0) begin mismatched++; $display("FAIL rst_mid rdy: got %0b required 0", rdy); end
    run_vec(0, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 64, 1'b0, -1, 0);
    check_out("rst_mid", c);
    check_idle("rst_mid", 64);
  endtask

  task automatic test_random();
    vec_t d, w;
    int b, ev, c;
    bit es;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = int'($urandom_range(0, 255)) - 128;
        w[i] = int'($urandom_range(0, 255)) - 128;
      end
      b = int'($urandom_range(0, 255)) - 128;
      if (v < 3) begin
        for (int i = 0; i < 4; i++) begin d[i] = d[i] / 8; w[i] = w[i] / 4; end
      end
      ev = model(b, d, w, es);
      run_vec(b, d, w, ev, es, -1, 0);
      check_out("random", c);
    end
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #2;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
